// File: rtl/flash_boot_loader_pkg.sv
// Shared definitions for the flash boot loader: state encoding, default sizes
// and the halfword-pair to SRAM-word byte reversal.
package flash_boot_loader_pkg;

   localparam int unsigned LOAD_WORDS_DEF = 1048576;
   localparam int unsigned TIMEOUT_DEF    = 4095;
   localparam int          CNT_W          = 21;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ_HI = 3'd1,
      ST_REQ_LO = 3'd2,
      ST_WRITE  = 3'd3,
      ST_FINISH = 3'd4,
      ST_ERROR  = 3'd5
   } boot_state_t;

   // Flash stores the image big-endian per halfword; the CPU fetches little-endian words.
   function automatic logic [31:0] boot_swap(input logic [15:0] hi, input logic [15:0] lo);
      return {lo[7:0], lo[15:8], hi[7:0], hi[15:8]};
   endfunction

endpackage

// File: rtl/flash_boot_loader_sram_mux.sv
// Instruction-SRAM port arbiter: the loader drives the SRAM while it owns the
// port, otherwise the CPU port passes straight through.
module boot_sram_mux
   import flash_boot_loader_pkg::*;
(
   input  logic        loader_owns,
   input  logic        ld_ce,
   input  logic        ld_we,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_wdata,
   input  logic [3:0]  ld_sel,
   input  logic        cpu_ce,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_sel,
   output logic [31:0] cpu_rdata,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_sel,
   input  logic [31:0] mem_rdata
);

   assign mem_ce    = loader_owns ? ld_ce    : cpu_ce;
   assign mem_we    = loader_owns ? ld_we    : cpu_we;
   assign mem_addr  = loader_owns ? ld_addr  : cpu_addr;
   assign mem_wdata = loader_owns ? ld_wdata : cpu_wdata;
   assign mem_sel   = loader_owns ? ld_sel   : cpu_sel;
   // The CPU sees zeros rather than stale image data while the loader owns the port.
   assign cpu_rdata = loader_owns ? 32'h0 : mem_rdata;

endmodule

// File: rtl/flash_boot_loader.sv
// Boot sequencer: copies the flash image into instruction SRAM, holding the CPU
// in reset until the copy is complete.
//
// state   | meaning
// IDLE    | CPU owns SRAM; waits for start_i or power-on boot
// REQ_HI  | fetching high halfword of the current word
// REQ_LO  | fetching low halfword of the current word
// WRITE   | single-cycle SRAM write of the assembled word
// FINISH  | last word written, CPU still held for one more cycle
// ERROR   | flash did not answer in time; CPU held until restart
module flash_boot_loader
   import flash_boot_loader_pkg::*;
#(
   parameter int unsigned LOAD_WORDS    = LOAD_WORDS_DEF,
   parameter int unsigned TIMEOUT       = TIMEOUT_DEF,
   parameter bit          BOOT_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   output logic        flash_req_o,
   output logic [21:0] flash_addr_o,
   input  logic        flash_ack_i,
   input  logic [15:0] flash_data_i,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   input  logic [3:0]  cpu_sel_i,
   output logic [31:0] cpu_data_o,
   output logic        mem_ce_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic [3:0]  mem_sel_o,
   input  logic [31:0] mem_data_i,
   output logic        cpu_rst_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [15:0] progress_o
);

   localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LOAD_WORDS - 1);

   boot_state_t      state, state_nxt;
   logic [CNT_W-1:0] word_cnt;
   logic [TMR_W-1:0] tmr;
   logic [15:0]      hi_q, lo_q;
   logic             done_q, error_q, boot_pend;
   logic             in_req, tmr_tc;
   logic             clr_load, cnt_inc, set_done, set_err, cap_hi, cap_lo;
   logic             loader_owns, ld_wr;

   assign in_req = (state == ST_REQ_HI) || (state == ST_REQ_LO);
   // Down-counter reloads on every ack; terminal count marks the TIMEOUT-th idle cycle.
   assign tmr_tc = (tmr == '0);

   always_comb begin
      state_nxt = state;
      clr_load  = 1'b0;
      cnt_inc   = 1'b0;
      set_done  = 1'b0;
      set_err   = 1'b0;
      cap_hi    = 1'b0;
      cap_lo    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (boot_pend || start_i) begin
               clr_load  = 1'b1;
               state_nxt = ST_REQ_HI;
            end
         end
         ST_REQ_HI: begin
            if (flash_ack_i) begin
               cap_hi    = 1'b1;
               state_nxt = ST_REQ_LO;
            end else if (tmr_tc) begin
               set_err   = 1'b1;
               state_nxt = ST_ERROR;
            end
         end
         ST_REQ_LO: begin
            if (flash_ack_i) begin
               cap_lo    = 1'b1;
               state_nxt = ST_WRITE;
            end else if (tmr_tc) begin
               set_err   = 1'b1;
               state_nxt = ST_ERROR;
            end
         end
         ST_WRITE: begin
            if (word_cnt == LAST_WORD) begin
               state_nxt = ST_FINISH;
            end else begin
               cnt_inc   = 1'b1;
               state_nxt = ST_REQ_HI;
            end
         end
         ST_FINISH: begin
            set_done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_ERROR: begin
            if (start_i) begin
               clr_load  = 1'b1;
               state_nxt = ST_REQ_HI;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         word_cnt  <= '0;
         tmr       <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         boot_pend <= BOOT_ON_RESET;
      end else begin
         state     <= state_nxt;
         boot_pend <= 1'b0;
         if (clr_load) begin
            word_cnt <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
         end else begin
            if (cnt_inc)  word_cnt <= word_cnt + CNT_W'(1);
            if (set_done) done_q   <= 1'b1;
            if (set_err)  error_q  <= 1'b1;
         end
         if (in_req && !flash_ack_i) tmr <= tmr - TMR_W'(1);
         else                        tmr <= TMR_LOAD;
      end
   end

   always_ff @(posedge clk) begin
      if (cap_hi) hi_q <= flash_data_i;
      if (cap_lo) lo_q <= flash_data_i;
   end

   // Outputs are qualified with rst_n so a reset landing mid-load issues no request or write.
   assign flash_req_o  = rst_n && in_req;
   assign flash_addr_o = flash_req_o ? {word_cnt, state == ST_REQ_LO} : 22'h0;
   assign busy_o       = rst_n && (in_req || state == ST_WRITE || state == ST_FINISH);
   assign cpu_rst_o    = !rst_n || (state != ST_IDLE) || boot_pend;
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign progress_o   = word_cnt[CNT_W-1:5];

   assign loader_owns = (state != ST_IDLE) || boot_pend;
   assign ld_wr       = rst_n && (state == ST_WRITE);

   boot_sram_mux u_sram_mux (
      .loader_owns (loader_owns),
      .ld_ce       (ld_wr),
      .ld_we       (ld_wr),
      .ld_addr     ({9'h0, word_cnt, 2'b00}),
      .ld_wdata    (boot_swap(hi_q, lo_q)),
      .ld_sel      (4'b1111),
      .cpu_ce      (cpu_ce_i),
      .cpu_we      (cpu_we_i),
      .cpu_addr    (cpu_addr_i),
      .cpu_wdata   (cpu_data_i),
      .cpu_sel     (cpu_sel_i),
      .cpu_rdata   (cpu_data_o),
      .mem_ce      (mem_ce_o),
      .mem_we      (mem_we_o),
      .mem_addr    (mem_addr_o),
      .mem_wdata   (mem_data_o),
      .mem_sel     (mem_sel_o),
      .mem_rdata   (mem_data_i)
   );

endmodule

// File: tb/tb_flash_boot_loader.sv
// Self-checking bench for flash_boot_loader: flash responder, SRAM write
// scoreboard and an image model built from the flash contents.
module tb_flash_boot_loader;

   localparam int NW  = 4;
   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst_n, start_i;
   logic        flash_req_o;
   logic [21:0] flash_addr_o;
   logic        flash_ack_i = 1'b0;
   logic [15:0] flash_data_i = 16'h0;
   logic        cpu_ce_i, cpu_we_i;
   logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
   logic [3:0]  cpu_sel_i;
   logic        mem_ce_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
   logic [3:0]  mem_sel_o;
   logic        cpu_rst_o, busy_o, done_o, error_o;
   logic [15:0] progress_o;

   always #5 clk = ~clk;

   flash_boot_loader #(
      .LOAD_WORDS    (NW),
      .TIMEOUT       (TMO),
      .BOOT_ON_RESET (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .flash_req_o  (flash_req_o),
      .flash_addr_o (flash_addr_o),
      .flash_ack_i  (flash_ack_i),
      .flash_data_i (flash_data_i),
      .cpu_ce_i     (cpu_ce_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_sel_i    (cpu_sel_i),
      .cpu_data_o   (cpu_data_o),
      .mem_ce_o     (mem_ce_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_sel_o    (mem_sel_o),
      .mem_data_i   (mem_data_i),
      .cpu_rst_o    (cpu_rst_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .progress_o   (progress_o)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] fl_mem [2*NW];
   bit          fl_en = 1'b0, fl_rand = 1'b0, fl_stray = 1'b0;
   int          fl_lat = 3, fl_cnt = 0, fl_tgt = 0;
   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];
   int          iso_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Flash: acks after fl_tgt waiting cycles with the stored halfword.
   always @(negedge clk) begin
      if (flash_ack_i || !flash_req_o) begin
         fl_cnt = 0;
         fl_tgt = fl_rand ? int'($urandom_range(0, 4)) : fl_lat;
      end
      flash_ack_i = 1'b0;
      if (flash_req_o && fl_en) begin
         if (fl_cnt >= fl_tgt) begin
            flash_ack_i  = 1'b1;
            flash_data_i = fl_mem[flash_addr_o[2:0]];
         end else begin
            fl_cnt++;
         end
      end else if (!flash_req_o && fl_stray) begin
         flash_ack_i  = 1'($urandom_range(0, 1));
         flash_data_i = 16'($urandom);
      end
   end

   // Loader-issued SRAM writes happen only while the CPU is held in reset.
   always @(negedge clk) begin
      if (cpu_rst_o === 1'b1 && mem_ce_o === 1'b1 && mem_we_o === 1'b1) begin
         wq_addr.push_back(mem_addr_o);
         wq_data.push_back(mem_data_o);
      end
   end

   function automatic logic [31:0] model_word(input int k);
      logic [31:0] w, r;
      w = {fl_mem[2*k], fl_mem[2*k+1]};
      for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
      return r;
   endfunction

   task automatic fill_mem(input bit rnd);
      for (int i = 0; i < 2*NW; i++) fl_mem[i] = rnd ? 16'($urandom) : 16'(i + 'h1200);
   endtask

   task automatic check_image(input string tag);
      check_val({tag, "_nwr"}, 32'(wq_addr.size()), 32'(NW));
      for (int k = 0; k < NW && k < wq_addr.size(); k++) begin
         check_val($sformatf("%s_addr%0d", tag, k), wq_addr[k], 32'(4*k));
         check_val($sformatf("%s_data%0d", tag, k), wq_data[k], model_word(k));
      end
      wq_addr.delete();
      wq_data.delete();
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input bit poke, input string tag);
      int i;
      for (i = 0; i < 2000; i++) begin
         if (!busy_o) break;
         if (cpu_data_o !== 32'h0 || cpu_rst_o !== 1'b1) iso_bad++;
         cpu_ce_i   = 1'b1;
         cpu_we_i   = 1'($urandom_range(0, 1));
         cpu_addr_i = $urandom;
         cpu_data_i = $urandom;
         mem_data_i = $urandom | 32'h1;
         start_i    = poke && ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end
      start_i = 1'b0;
      check_val({tag, "_ended"}, 32'(i < 2000), 32'h1);
      check_val({tag, "_iso"}, 32'(iso_bad), 32'h0);
      iso_bad = 0;
   endtask

   initial begin
      int n, bad;
      bit found;
      logic [31:0] a, d, md;
      logic [3:0]  s;
      logic        ce, we;

      rst_n = 1'b0; start_i = 1'b0;
      cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
      mem_data_i = '0;
      fill_mem(1'b0);
      fl_en = 1'b1; fl_lat = 3;
      repeat (3) @(negedge clk);

      check_val("rst_cpu_rst", 32'(cpu_rst_o), 32'h1);
      check_val("rst_busy", 32'(busy_o), 32'h0);
      check_val("rst_done", 32'(done_o), 32'h0);
      check_val("rst_error", 32'(error_o), 32'h0);
      check_val("rst_req", 32'(flash_req_o), 32'h0);
      check_val("rst_faddr", 32'(flash_addr_o), 32'h0);
      check_val("rst_progress", 32'(progress_o), 32'h0);

      // power-on boot
      rst_n = 1'b1;
      #1;
      check_val("boot_hold_cpu", 32'(cpu_rst_o), 32'h1);
      @(negedge clk);
      check_val("boot_req", 32'(flash_req_o), 32'h1);
      check_val("boot_faddr", 32'(flash_addr_o), 32'h0);
      check_val("boot_busy", 32'(busy_o), 32'h1);
      wait_idle(1'b0, "boot");
      check_val("boot_done", 32'(done_o), 32'h1);
      check_val("boot_error", 32'(error_o), 32'h0);
      check_val("boot_cpu_released", 32'(cpu_rst_o), 32'h0);
      check_val("boot_word0", (wq_data.size() > 0) ? wq_data[0] : 32'h0, 32'h01120012);
      check_image("boot");

      // IDLE pass-through
      for (int t = 0; t < 8; t++) begin
         ce = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         a  = (t == 0) ? 32'h100 : $urandom;
         d  = $urandom;
         s  = 4'($urandom);
         md = (t == 0) ? 32'hDEADBEEF : $urandom;
         cpu_ce_i = ce; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d; cpu_sel_i = s; mem_data_i = md;
         #1;
         check_val($sformatf("pt_ce%0d", t), 32'(mem_ce_o), 32'(ce));
         check_val($sformatf("pt_we%0d", t), 32'(mem_we_o), 32'(we));
         check_val($sformatf("pt_addr%0d", t), mem_addr_o, a);
         check_val($sformatf("pt_wdata%0d", t), mem_data_o, d);
         check_val($sformatf("pt_sel%0d", t), 32'(mem_sel_o), 32'(s));
         check_val($sformatf("pt_rdata%0d", t), cpu_data_o, md);
         @(negedge clk);
      end

      // acks arriving in IDLE are ignored
      cpu_ce_i = 1'b0;
      fl_stray = 1'b1;
      bad = 0;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         if (busy_o !== 1'b0 || cpu_rst_o !== 1'b0 || flash_req_o !== 1'b0 || done_o !== 1'b1) bad++;
      end
      fl_stray = 1'b0;
      @(negedge clk);
      check_val("stray_idle", 32'(bad), 32'h0);
      check_val("stray_nwr", 32'(wq_addr.size()), 32'h0);

      // random images, random latency, start_i poked while busy
      fl_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         fill_mem(1'b1);
         pulse_start();
         check_val($sformatf("rnd%0d_done_clr", r), 32'(done_o), 32'h0);
         check_val($sformatf("rnd%0d_faddr0", r), 32'(flash_addr_o), 32'h0);
         wait_idle(1'b1, $sformatf("rnd%0d", r));
         check_val($sformatf("rnd%0d_done", r), 32'(done_o), 32'h1);
         check_val($sformatf("rnd%0d_error", r), 32'(error_o), 32'h0);
         check_image($sformatf("rnd%0d", r));
      end
      fl_rand = 1'b0;

      // flash never answers
      fl_en = 1'b0;
      pulse_start();
      n = 0;
      for (int i = 0; i < 100 && error_o !== 1'b1; i++) begin
         if (flash_req_o === 1'b1) n++;
         @(negedge clk);
      end
      check_val("tmo_cycles", 32'(n), 32'(TMO));
      check_val("tmo_error", 32'(error_o), 32'h1);
      check_val("tmo_cpu_rst", 32'(cpu_rst_o), 32'h1);
      check_val("tmo_busy", 32'(busy_o), 32'h0);
      check_val("tmo_req", 32'(flash_req_o), 32'h0);
      cpu_ce_i = 1'b1; cpu_we_i = 1'b1;
      repeat (3) @(negedge clk);
      check_val("err_mem_ce", 32'(mem_ce_o), 32'h0);
      check_val("err_cpu_rst", 32'(cpu_rst_o), 32'h1);
      check_val("err_sticky", 32'(error_o), 32'h1);
      check_val("tmo_nwr", 32'(wq_addr.size()), 32'h0);

      // restart from ERROR
      fill_mem(1'b1);
      fl_en = 1'b1; fl_lat = int'($urandom_range(0, 4));
      pulse_start();
      check_val("restart_req", 32'(flash_req_o), 32'h1);
      check_val("restart_faddr", 32'(flash_addr_o), 32'h0);
      check_val("restart_err_clr", 32'(error_o), 32'h0);
      wait_idle(1'b0, "restart");
      check_val("restart_done", 32'(done_o), 32'h1);
      check_image("restart");

      // ack on the last allowed cycle is accepted
      fl_lat = TMO - 1;
      pulse_start();
      wait_idle(1'b0, "edge_ok");
      check_val("edge_ok_error", 32'(error_o), 32'h0);
      check_val("edge_ok_done", 32'(done_o), 32'h1);
      check_image("edge_ok");

      // ack one cycle too late
      fl_lat = TMO;
      pulse_start();
      wait_idle(1'b0, "edge_late");
      check_val("edge_late_error", 32'(error_o), 32'h1);
      check_val("edge_late_nwr", 32'(wq_addr.size()), 32'h0);

      // reset during REQ_LO of word 2
      fl_lat = 2;
      fill_mem(1'b1);
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (flash_req_o === 1'b1 && flash_addr_o === 22'd5) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_val("mid_found", 32'(found), 32'h1);
      check_val("mid_prerst_nwr", 32'(wq_addr.size()), 32'h2);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("mid_rst_nwr", 32'(wq_addr.size()), 32'h2);
      check_val("mid_rst_busy", 32'(busy_o), 32'h0);
      check_val("mid_rst_cpu_rst", 32'(cpu_rst_o), 32'h1);
      check_val("mid_rst_req", 32'(flash_req_o), 32'h0);
      check_val("mid_rst_done", 32'(done_o), 32'h0);
      wq_addr.delete();
      wq_data.delete();
      rst_n = 1'b1;
      @(negedge clk);
      check_val("reload_req", 32'(flash_req_o), 32'h1);
      check_val("reload_faddr", 32'(flash_addr_o), 32'h0);
      wait_idle(1'b0, "reload");
      check_val("reload_done", 32'(done_o), 32'h1);
      check_image("reload");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
      $fatal(1);
   end

endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
- Boot sequencer that copies a program image from the parallel Flash controller into the instruction SRAM, then hands the SRAM port to the CPU.
- Sits between the Flash read controller, the instruction-RAM wrapper and the CPU instruction port.
- Holds the CPU in reset while loading.
- Acts as a two-master arbiter on the SRAM port: the loader owns it while loading, the CPU owns it otherwise.

Parameters:
- LOAD_WORDS, 1048576: number of 32-bit words copied (4 MB). Must be ≥1.
- TIMEOUT, 4095: maximum cycles to wait for flash_ack_i before aborting.
- BOOT_ON_RESET, 1: if 1, loading starts automatically when rst_n deasserts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- start_i  in  1  one-cycle load request; honoured only in IDLE or ERROR
- flash_req_o  out  1  read request, held high until ack
- flash_addr_o  out  22  halfword address
- flash_ack_i  in  1  one-cycle pulse; flash_data_i valid in the same cycle
- flash_data_i  in  16  read halfword
- cpu_ce_i  in  1  CPU port chip enable
- cpu_we_i  in  1  CPU port write enable
- cpu_addr_i  in  32  CPU port byte address
- cpu_data_i  in  32  CPU port write data
- cpu_sel_i  in  4  CPU port byte select
- cpu_data_o  out  32  CPU read data
- mem_ce_o  out  1  SRAM wrapper chip enable
- mem_we_o  out  1  SRAM wrapper write enable
- mem_addr_o  out  32  SRAM wrapper byte address
- mem_data_o  out  32  SRAM wrapper write data
- mem_sel_o  out  4  SRAM wrapper byte select
- mem_data_i  in  32  SRAM read data
- cpu_rst_o  out  1  CPU reset, active high
- busy_o  out  1  loading in progress
- done_o  out  1  sticky: last load completed
- error_o  out  1  sticky: last load timed out
- progress_o  out  16  word counter bits [20:5], for LEDs

Behaviour:
- States: IDLE, REQ_HI, REQ_LO, WRITE, FINISH, ERROR. Registered FSM.
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE; word_cnt=0, timer=0.
  - done_o=0, error_o=0, busy_o=0, cpu_rst_o=1, flash_req_o=0, flash_addr_o=0.
  - First cycle after release: if BOOT_ON_RESET=1, enter REQ_HI; otherwise stay in IDLE with cpu_rst_o=0.
  - Reset mid-load discards the partial word; no SRAM write is issued in the reset cycle.
- IDLE:
  - cpu_rst_o=0.
  - mem_* is a direct combinational pass-through of cpu_*.
  - cpu_data_o=mem_data_i.
  - start_i=1: clear word_cnt, done_o and error_o, then go to REQ_HI.
- REQ_HI:
  - flash_req_o=1, flash_addr_o={word_cnt,1'b0}.
  - On flash_ack_i: hi←flash_data_i, go to REQ_LO.
- REQ_LO:
  - flash_addr_o={word_cnt,1'b1}.
  - On flash_ack_i: lo←flash_data_i, go to WRITE.
- WRITE (exactly one cycle):
  - mem_ce_o=1, mem_we_o=1, mem_sel_o=4'b1111.
  - mem_addr_o={word_cnt,2'b00}, zero-extended to 32 bits.
  - mem_data_o={lo[7:0],lo[15:8],hi[7:0],hi[15:8]} (byte-reversed {hi,lo}).
  - If word_cnt==LOAD_WORDS-1, go to FINISH; otherwise word_cnt+1 and go to REQ_HI.
- FINISH (one cycle): cpu_rst_o=1, done_o←1, then go to IDLE. The CPU leaves reset on the first IDLE cycle.
- Timeout:
  - timer counts cycles in REQ_HI/REQ_LO without ack and clears on every ack.
  - Reaching TIMEOUT: error_o←1, flash_req_o←0, go to ERROR.
- ERROR: cpu_rst_o=1, mem_ce_o=0. start_i restarts the load from word 0.
- During REQ_HI, REQ_LO, WRITE and FINISH:
  - busy_o=1 and cpu_rst_o=1.
  - CPU port is ignored; cpu_data_o=0.
  - mem_ce_o=0 except in WRITE.
- Simultaneous events:
  - start_i while busy is ignored.
  - flash_ack_i outside REQ_* is ignored.
  - flash_ack_i in the same cycle the timer reaches TIMEOUT: the ack wins.
- Widths:
  - word_cnt is 21 bits.
  - flash_addr_o bit 0 selects lo/hi.
  - progress_o=word_cnt[20:5].

Decomposition:
- Shared defines file:
  - state encodings (3-bit localparams);
  - the BOOT byte-reverse as a function macro;
  - default LOAD_WORDS and TIMEOUT.
- One natural sub-module: boot_sram_mux, the combinational CPU/loader port multiplexer selected by a loader_owns signal. The FSM, counters and timer stay in flash_boot_loader.

Test Plan:
- BOOT_ON_RESET=1, LOAD_WORDS=4, Flash model returns addr+0x1200 after 3 cycles:
  - word 0 written = 0x01120012;
  - 4 writes at byte addresses 0x0, 0x4, 0x8, 0xC;
  - cpu_rst_o falls one cycle after FINISH;
  - done_o=1.
- In IDLE, cpu_ce_i=1, cpu_addr_i=0x100, mem_data_i=0xDEADBEEF → mem_addr_o=0x100 and cpu_data_o=0xDEADBEEF in the same cycle.
- Flash model never acks, TIMEOUT=15 → error_o=1 after 15 cycles in REQ_HI, cpu_rst_o stays 1; a start_i pulse restarts at flash_addr_o=0.
- rst_n pulsed low while in REQ_LO of word 2 → no write is issued; reload begins at halfword address 0.
- start_i asserted mid-load and ack pulses arriving in IDLE → no state change, word_cnt unchanged.
- Ack arriving in the same cycle the timer reaches TIMEOUT → data is accepted, error_o stays 0.
